// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: machine word, instruction word and queue entry.
package cpuDefine;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0]  RESET_PC_DEF = 32'h1c00_0000;

    typedef logic [XLEN_DEF-1:0] DType;
    typedef logic [31:0]         Instr;

    typedef struct packed {
        DType pc;
        Instr instr;
    } FetchEntry;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush has priority over push and pop.
// The head reads as zero whenever the FIFO is empty.
module fetch_fifo
    import cpuDefine::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  FetchEntry     push_data,
    output FetchEntry     head,
    output logic [CW-1:0] count
);

    FetchEntry       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (reset && !flush && push) mem[wr_ptr] <= push_data;
    end

    // Head entry, forced to zero when empty.
    always_comb begin
        head = '0;
        if (count != '0) head = mem[rd_ptr];
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Decoupled instruction fetch: owns the fetch PC, issues in-order requests
// under a credit limit, queues responses with their PCs, and flushes on redirect.
module if_fetch_unit
    import cpuDefine::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW:0]     in_flight;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    FetchEntry       push_entry;
    FetchEntry       head;

    // Handshake and credit logic: queued plus outstanding never exceeds QDEPTH.
    always_comb begin
        in_flight       = {1'b0, q_count} + {1'b0, outstanding};
        redirect_target = redirect_pc & ~XLEN'(3);
        imem_req_valid  = reset && !redirect_valid && (in_flight < (CW+1)'(QDEPTH));
        imem_req_addr   = fetch_pc;
        req_fire        = imem_req_valid && imem_req_ready;
        resp_fire       = imem_resp_valid;
        push            = resp_fire && !redirect_valid && (drop_cnt == '0);
        out_valid       = (q_count != '0) && !redirect_valid;
        pop             = out_valid && out_ready;
        push_entry      = '0;
        push_entry.pc   = DType'(resp_pc);
        push_entry.instr = imem_resp_instr;
        out_instr       = head.instr;
        out_pc          = XLEN'(head.pc);
    end

    // PC and credit/drop counters; a redirect converts every response still
    // owed (minus one arriving now) into a response to be discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= outstanding - CW'(resp_fire);
            drop_cnt    <= outstanding - CW'(resp_fire);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
            if (resp_fire) begin
                if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                else                resp_pc  <= resp_pc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a fixed-latency in-order memory model.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t mq[$];

    if_fetch_unit #(
        .XLEN     (32),
        .QDEPTH   (4),
        .RESET_PC (32'h1c00_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_instr (imem_resp_instr),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: record accepted requests mid-cycle, answer lat cycles later, instr = ~addr.
    always begin
        @(negedge clk);
        if (!reset) mq.delete();
        else if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
        if (reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_instr = ~mq[0].addr;
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_instr = '0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Hold reset, check reset outputs, release; returns inside cycle 0.
    task automatic start(input int l, input logic ordy);
        lat            = l;
        out_ready      = ordy;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        reset          = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_pc", out_pc, 0);
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        int nfire;
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_instr = '0;
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        out_ready       = 1'b0;

        // Streaming at latency 1: one address per cycle, out_pc two cycles behind.
        start(1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("t1_req_valid", imem_req_valid, 1);
            check_eq("t1_addr", imem_req_addr, 32'h1c00_0000 + 32'(4 * k));
            if (k >= 2) begin
                check_eq("t1_out_valid", out_valid, 1);
                check_eq("t1_out_pc", out_pc, 32'h1c00_0000 + 32'(4 * (k - 2)));
                check_eq("t1_out_instr", out_instr, ~(32'h1c00_0000 + 32'(4 * (k - 2))));
            end else begin
                check_eq("t1_out_empty", out_valid, 0);
            end
            next_cycle();
        end

        // Back-pressure: exactly QDEPTH requests, then drain in order and resume.
        start(1, 1'b0);
        nfire = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nfire++;
            next_cycle();
        end
        check_eq("t2_fire_count", nfire, 4);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_stalled", imem_req_valid, 0);
        check_eq("t2_pop0_pc", out_pc, 32'h1c00_0000);
        for (int j = 1; j < 4; j++) begin
            next_cycle();
            @(negedge clk);
            check_eq("t2_pop_pc", out_pc, 32'h1c00_0000 + 32'(4 * j));
            if (j == 1) begin
                check_eq("t2_resume_valid", imem_req_valid, 1);
                check_eq("t2_resume_addr", imem_req_addr, 32'h1c00_0010);
            end
        end
        next_cycle();
        @(negedge clk);
        check_eq("t2_after_drain_pc", out_pc, 32'h1c00_0010);

        // Redirect with 3 outstanding at latency 3: stale responses dropped.
        start(3, 1'b1);
        @(negedge clk);
        check_eq("t3_first_addr", imem_req_addr, 32'h1c00_0000);
        repeat (3) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0103;
        @(negedge clk);
        check_eq("t3_no_req_redirect", imem_req_valid, 0);
        check_eq("t3_no_out_redirect", out_valid, 0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t3_new_req_valid", imem_req_valid, 1);
        check_eq("t3_new_addr", imem_req_addr, 32'h1c00_0100);
        for (int k = 5; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            check_eq("t3_stale_dropped", out_valid, 0);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check_eq("t3_out_valid", out_valid, 1);
            check_eq("t3_out_pc", out_pc, 32'h1c00_0100 + 32'(4 * k));
        end

        // Redirect coinciding with a response and a ready consumer.
        start(1, 1'b1);
        repeat (2) next_cycle();
        @(negedge clk);
        check_eq("t4_pre_pc", out_pc, 32'h1c00_0000);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1c00_0200;
        @(negedge clk);
        check_eq("t4_out_gated", out_valid, 0);
        check_eq("t4_req_gated", imem_req_valid, 0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_empty_valid", out_valid, 0);
        check_eq("t4_empty_pc", out_pc, 0);
        check_eq("t4_empty_instr", out_instr, 0);
        check_eq("t4_new_addr", imem_req_addr, 32'h1c00_0200);
        next_cycle();
        @(negedge clk);
        check_eq("t4_no_stale", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("t4_out_pc", out_pc, 32'h1c00_0200);
        check_eq("t4_out_instr", out_instr, ~32'h1c00_0200);

        // Reset mid-stream with 2 requests outstanding.
        start(3, 1'b1);
        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_rst_req", imem_req_valid, 0);
        check_eq("t5_rst_out", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("t5_rst_req_next", imem_req_valid, 0);
        check_eq("t5_rst_out_next", out_valid, 0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_restart_valid", imem_req_valid, 1);
        check_eq("t5_restart_addr", imem_req_addr, 32'h1c00_0000);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check_eq("t5_no_stale", out_valid, 0);
        end
        next_cycle();
        @(negedge clk);
        check_eq("t5_out_pc", out_pc, 32'h1c00_0000);

        // Address wrap from ffff_fffc to 0.
        start(1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        @(negedge clk);
        check_eq("t6_req_gated", imem_req_valid, 0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_addr_top", imem_req_addr, 32'hffff_fffc);
        next_cycle();
        @(negedge clk);
        check_eq("t6_addr_wrap", imem_req_addr, 32'h0000_0000);
        next_cycle();
        @(negedge clk);
        check_eq("t6_addr_4", imem_req_addr, 32'h0000_0004);
        check_eq("t6_out_pc_top", out_pc, 32'hffff_fffc);
        next_cycle();
        @(negedge clk);
        check_eq("t6_out_pc_wrap", out_pc, 32'h0000_0000);
        check_eq("t6_out_instr_wrap", out_instr, 32'hffff_ffff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
